mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-outstanding memory bus between the fetch stage's instruction read port and the mem stage's data read/write ports.
- Sits between the pipeline and the MMU. It presents the same instruction handshake fetch already uses (RDEN/RIADDR in, RVALID/ROADDR/RDATA out).
- It also generates the MMU_WAIT stall for fetch.
- It sequences bus transactions with a small FSM and applies data-first priority with an anti-starvation limit for instruction fetch.

Parameters:
DATA_STREAK_MAX, 4, consecutive data grants allowed while a fetch is pending before fetch is forced next (1..15)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-low reset
FLUSH  in  1  pipeline flush; cancels the instruction response
INST_RDEN  in  1  fetch read request (level)
INST_RIADDR  in  32  fetch address
INST_RVALID  out  1  fetch response valid (1-cycle pulse)
INST_ROADDR  out  32  address of the returned instruction
INST_RDATA  out  32  returned instruction
MMU_WAIT  out  1  fetch must hold PC
DATA_RDEN  in  1  load request (level)
DATA_RADDR  in  32  load address
DATA_RVALID  out  1  load data valid (1-cycle pulse)
DATA_RDATA  out  32  load data
DATA_WREN  in  1  store request (level)
DATA_WADDR  in  32  store address
DATA_WDATA  in  32  store data
DATA_WSTRB  in  4  store byte enables
DATA_WDONE  out  1  store complete (1-cycle pulse)
MEM_REQ  out  1  bus request, held until MEM_ACK
MEM_WE  out  1  1 = write
MEM_ADDR  out  32  bus address
MEM_WDATA  out  32  bus write data
MEM_STRB  out  4  byte enables (4'hF for reads)
MEM_ACK  in  1  transaction done; MEM_RDATA valid this cycle
MEM_RDATA  in  32  bus read data

Behaviour:
- Reset (RST=0, async): state IDLE. All registered outputs are 0: MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_STRB, all RVALID/WDONE, ROADDR/RDATA, streak counter and drop flag.
- States:
  - IDLE: sample requests and pick a winner.
  - BUSY_I, BUSY_R, BUSY_W: MEM_REQ=1, waiting for MEM_ACK.
  - RESP: response pulse cycle, then return to IDLE.
- Requesters hold request and address/data stable until their response pulse. Requests are level-sensitive.
- Arbitration in IDLE, in priority order:
  - If streak==DATA_STREAK_MAX and INST_RDEN && !FLUSH, grant inst.
  - Otherwise DATA_WREN wins, then DATA_RDEN, then INST_RDEN && !FLUSH.
  - No request: stay in IDLE.
- Grant latching: the winner's address, data and strobe are registered into the MEM_* outputs. MEM_REQ rises on the cycle after the IDLE decision.
- Streak counter (4-bit):
  - A data grant while INST_RDEN=1 increments it, saturating at DATA_STREAK_MAX.
  - An inst grant clears it.
  - An IDLE cycle with INST_RDEN=0 clears it.
- BUSY_x: MEM_REQ and all MEM_* outputs stay stable until MEM_ACK. The bus may ACK in the first BUSY cycle. On ACK, capture MEM_RDATA and go to RESP.
- RESP, for exactly one cycle:
  - Read/write grants pulse DATA_RVALID (with captured data) or DATA_WDONE.
  - An inst grant pulses INST_RVALID with ROADDR = latched address, unless the drop flag is set.
  - Then go to IDLE.
  - Minimum request-to-response latency is 2 cycles: request at t, MEM_REQ at t+1, ACK at t+1, pulse at t+2.
- No back-to-back: the next grant is decided in the IDLE cycle after RESP. Bus issue rate is at most 1 transaction per 3 cycles.
- FLUSH:
  - In BUSY_I or RESP-for-inst, set the drop flag. The bus transaction still completes, but INST_RVALID is suppressed.
  - The drop flag clears on entry to IDLE.
  - FLUSH in IDLE blocks an inst grant that cycle only.
  - FLUSH has no effect on data transactions.
- MMU_WAIT (combinational) = INST_RDEN && !INST_RVALID.
- RDATA/ROADDR outputs hold their last value outside valid pulses.
- Simultaneous FLUSH and ACK in BUSY_I: the response is dropped.
- Reset mid-transaction aborts immediately: MEM_REQ=0 and no pulses are issued.

Test Plan:
- Single fetch, INST_RIADDR=0x2000_0000, ACK on first BUSY cycle, MEM_RDATA=0x0000_0013 -> MEM_REQ at t+1 with MEM_WE=0/STRB=F; INST_RVALID at t+2 with ROADDR=0x2000_0000, RDATA=0x13; MMU_WAIT high t..t+1.
- DATA_WREN (addr 0x100, data 0xDEADBEEF, strb 0x3) + DATA_RDEN + INST_RDEN all raised together -> grant order write, read, fetch. Bus shows WE=1/STRB=3 first. Fetch completes third.
- Continuous DATA_RDEN plus INST_RDEN held, DATA_STREAK_MAX=4 -> exactly 4 data transactions, then 1 fetch, then data resumes.
- Fetch issued, FLUSH pulsed while ACK is held off 3 cycles -> bus completes, INST_RVALID stays 0. A new fetch afterwards returns normally.
- ACK delayed 5 cycles -> MEM_ADDR/MEM_REQ stable throughout; single response pulse.
- RST asserted low during BUSY_R -> MEM_REQ and all pulses drop immediately. After release, state is IDLE and a new fetch works.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-outstanding memory bus between fetch (read-only) and the data read/write ports,
//           using data-first priority with a bounded data streak so that fetch cannot starve.
// Latency : request seen in IDLE at cycle t, MEM_REQ at t+1, response pulse one cycle after MEM_ACK (minimum t+2).
//           Backpressure: requesters hold request, address and data until their pulse; MEM_* holds until MEM_ACK.
//
// Ports:
//   CLK, RST (async, active-low)    FLUSH cancels any in-flight instruction response
//   INST_RDEN/INST_RIADDR  -> INST_RVALID/INST_ROADDR/INST_RDATA, MMU_WAIT (fetch must hold PC)
//   DATA_RDEN/DATA_RADDR   -> DATA_RVALID/DATA_RDATA
//   DATA_WREN/DATA_WADDR/DATA_WDATA/DATA_WSTRB -> DATA_WDONE
//   MEM_REQ/MEM_WE/MEM_ADDR/MEM_WDATA/MEM_STRB <- MEM_ACK/MEM_RDATA (bus side)
module mem_port_arbiter #(
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_ROADDR,
  output logic [31:0] INST_RDATA,
  output logic        MMU_WAIT,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  input  logic        DATA_WREN,
  input  logic [31:0] DATA_WADDR,
  input  logic [31:0] DATA_WDATA,
  input  logic [3:0]  DATA_WSTRB,
  output logic        DATA_WDONE,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_STRB,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA
);

  localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_R, BUSY_W, RESP} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_INST, GNT_RD, GNT_WR} gnt_t;

  state_t      state_q, state_d;
  gnt_t        gnt;
  logic        inst_ok;
  logic [31:0] gnt_addr;
  logic [31:0] gnt_wdata;
  logic [3:0]  gnt_strb;
  logic [3:0]  streak_q;
  logic        drop_q;
  logic        inst_pls_q;

  // A flush landing in the response cycle itself still kills the pulse,
  // so the registered pulse is gated by FLUSH on its way out.
  assign INST_RVALID = inst_pls_q && !FLUSH;
  assign MMU_WAIT    = INST_RDEN && !INST_RVALID;

  assign inst_ok = INST_RDEN && !FLUSH;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and grant selection
  always_comb begin
    state_d   = state_q;
    gnt       = GNT_NONE;
    gnt_addr  = 32'h0;
    gnt_wdata = 32'h0;
    gnt_strb  = 4'hF;
    case (state_q)
      IDLE: begin
        // Fetch is forced once data has won STREAK_MAX times in a row
        // while fetch was waiting.
        if (streak_q == STREAK_MAX && inst_ok) begin
          gnt = GNT_INST;
        end else if (DATA_WREN) begin
          gnt = GNT_WR;
        end else if (DATA_RDEN) begin
          gnt = GNT_RD;
        end else if (inst_ok) begin
          gnt = GNT_INST;
        end
        case (gnt)
          GNT_INST: begin
            state_d  = BUSY_I;
            gnt_addr = INST_RIADDR;
          end
          GNT_RD: begin
            state_d  = BUSY_R;
            gnt_addr = DATA_RADDR;
          end
          GNT_WR: begin
            state_d   = BUSY_W;
            gnt_addr  = DATA_WADDR;
            gnt_wdata = DATA_WDATA;
            gnt_strb  = DATA_WSTRB;
          end
          default: state_d = IDLE;
        endcase
      end
      BUSY_I, BUSY_R, BUSY_W: begin
        if (MEM_ACK) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs, response pulses, streak counter and drop flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      MEM_REQ     <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= 32'h0;
      MEM_WDATA   <= 32'h0;
      MEM_STRB    <= 4'h0;
      inst_pls_q  <= 1'b0;
      INST_ROADDR <= 32'h0;
      INST_RDATA  <= 32'h0;
      DATA_RVALID <= 1'b0;
      DATA_RDATA  <= 32'h0;
      DATA_WDONE  <= 1'b0;
      streak_q    <= 4'h0;
      drop_q      <= 1'b0;
    end else begin
      inst_pls_q  <= 1'b0;
      DATA_RVALID <= 1'b0;
      DATA_WDONE  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt != GNT_NONE) begin
            MEM_REQ   <= 1'b1;
            MEM_WE    <= (gnt == GNT_WR);
            MEM_ADDR  <= gnt_addr;
            MEM_WDATA <= gnt_wdata;
            MEM_STRB  <= gnt_strb;
          end
          if (gnt == GNT_INST || !INST_RDEN) begin
            streak_q <= 4'h0;
          end else if ((gnt == GNT_RD || gnt == GNT_WR) && streak_q != STREAK_MAX) begin
            streak_q <= streak_q + 4'h1;
          end
        end
        BUSY_I, BUSY_R, BUSY_W: begin
          if (state_q == BUSY_I && FLUSH) begin
            drop_q <= 1'b1;
          end
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            case (state_q)
              BUSY_I: begin
                // FLUSH coinciding with ACK drops the response too.
                if (!drop_q && !FLUSH) begin
                  inst_pls_q  <= 1'b1;
                  INST_ROADDR <= MEM_ADDR;
                  INST_RDATA  <= MEM_RDATA;
                end
              end
              BUSY_R: begin
                DATA_RVALID <= 1'b1;
                DATA_RDATA  <= MEM_RDATA;
              end
              default: DATA_WDONE <= 1'b1;
            endcase
          end
        end
        RESP: begin
          // Leaving for IDLE: forget any flush of the finished fetch.
          drop_q <= 1'b0;
        end
        default: drop_q <= 1'b0;
      endcase
    end
  end

endmodule
